// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that lends one unsigned W-bit comparator to N requesters.
// One request is in flight at a time: IDLE (grant) -> COMPARE -> RESPOND (hold until consumed).
module cmp_share_arbiter #(
  parameter int N = 4,
  parameter int W = 2,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_gt,
  output logic           rsp_eq,
  output logic           rsp_lt,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] gid_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_gt_q;
  logic           rsp_eq_q;
  logic           rsp_lt_q;

  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic [IDW-1:0] rr_ptr_d;

  logic [W-1:0]   a_arr [N];
  logic [W-1:0]   b_arr [N];

  // Both operands are < N, so a single conditional subtraction implements mod N.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(N)) s = s - 32'(N);
    return s[IDW-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // Scan downward so the last hit is the nearest valid index at or after rr_ptr.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_idx = wrap_add(rr_ptr_q, k);
        grant_any = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign req_ready[gi] = !rst && (state_q == IDLE) && grant_any &&
                             (grant_idx == IDW'(gi));
    end
  endgenerate

  assign rr_ptr_d = wrap_add(gid_q, 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q     <= a_arr[grant_idx];
            b_q     <= b_arr[grant_idx];
            gid_q   <= grant_idx;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          rsp_gt_q    <= (a_q > b_q);
          rsp_eq_q    <= (a_q == b_q);
          rsp_lt_q    <= (a_q < b_q);
          rsp_id_q    <= gid_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = rsp_gt_q;
  assign rsp_eq    = rsp_eq_q;
  assign rsp_lt    = rsp_lt_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Randomised scoreboard bench for cmp_share_arbiter (N=4, W=2) with a
// transaction-level reference model of grant order, timing and results.
module tb_cmp_share_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0] req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic         rsp_gt;
  logic         rsp_eq;
  logic         rsp_lt;
  logic         busy;

  cmp_share_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_eq    (rsp_eq),
    .rsp_lt    (rsp_lt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit gt;
    bit eq;
    bit lt;
  } exp_t;

  exp_t     sb[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       m_rr     = 0;
  int       grant_cyc = 0;
  bit       m_busy   = 0;
  logic [N-1:0] hs_mask = '0;
  bit       refill   = 0;
  bit       rand_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    int a;
    int b;
    bit exp_rv;
    exp_t e;
    cyc++;
    if (rst) begin
      sb.delete();
      m_busy  = 0;
      m_rr    = 0;
      hs_mask = '0;
      check("reset_outputs",
            32'({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy}), 32'd0);
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(m_busy));
      exp_rv = m_busy && (cyc >= grant_cyc + 2);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (rsp_valid && sb.size() > 0) begin
        e = sb[0];
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_flags", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'({e.gt, e.eq, e.lt}));
      end else if (!rsp_valid) begin
        check("flags_idle", 32'({rsp_gt, rsp_eq, rsp_lt}), 32'd0);
        if (!m_busy && req_valid == '0) check("rsp_id_idle", 32'(rsp_id), 32'd0);
      end
      hs_mask = req_ready & req_valid;
      if (exp_rv && rsp_ready && sb.size() > 0) begin
        m_rr = (sb[0].id + 1) % N;
        void'(sb.pop_front());
        m_busy = 0;
      end
      if (g >= 0) begin
        a = int'(req_a[g*W +: W]);
        b = int'(req_b[g*W +: W]);
        e.id = g;
        e.gt = (a > b);
        e.eq = (a == b);
        e.lt = (a < b);
        sb.push_back(e);
        m_busy    = 1;
        grant_cyc = cyc;
        $display("grant id=%0d a=%0d b=%0d cycle %0d", g, a, b, cyc);
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = W'(a);
    req_b[i*W +: W]  = W'(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i]) begin
        if (refill) set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        else req_valid[i] = 1'b0;
      end else if (rand_mode) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 9) < 3)
            set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (rand_mode) rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("async_reset", 32'({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit got;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single request, gt result, id 0
    set_req(0, 2, 1);
    repeat (6) step();
    // eq on requester 1 then lt on requester 2
    set_req(1, 3, 3);
    set_req(2, 0, 3);
    repeat (10) step();

    // round robin with all four held after reset
    @(posedge clk);
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    refill = 1;
    repeat (16) step();
    refill = 0;
    repeat (15) step();

    // fairness between requesters 1 and 3
    set_req(1, 1, 0);
    set_req(3, 0, 1);
    refill = 1;
    repeat (12) step();
    refill = 0;
    repeat (8) step();

    // backpressure: hold the response for several cycles
    rsp_ready = 1'b0;
    set_req(0, 1, 2);
    repeat (10) step();
    rsp_ready = 1'b1;
    repeat (4) step();

    // reset while the request is in COMPARE; next grant must restart at index 0
    set_req(1, 2, 2);
    repeat (4) step();
    set_req(2, 3, 1);
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      step();
      got = hs_mask[2];
    end
    check("grant_timeout", 32'(got), 32'd1);
    pulse_reset();
    for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    repeat (20) step();

    // randomised traffic with backpressure and dropped requests
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 50 && (sb.size() > 0 || m_busy); t++) step();
    check("drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
